// File: rtl/core_mem_port_pkg.sv
// rtl/core_mem_port_pkg.sv - shared memory port widths, FSM states and request record
package core_mem_port_pkg;

    localparam int BANK_W  = 4;
    localparam int OFFS_W  = 8;
    localparam int ADDR_W  = BANK_W + OFFS_W;
    localparam int DATA_W  = 8;
    localparam int N_BANKS = 16;
    localparam int REQ_W   = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/core_mem_port_req_fifo.sv
// rtl/core_mem_port_req_fifo.sv - synchronous request queue with full/empty flags
module core_mem_port_req_fifo
    import core_mem_port_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [REQ_W-1:0] data_i,
    input  logic             pop_i,
    output logic [REQ_W-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             empty_next_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [REQ_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             do_push;
    logic             do_pop;

    // Flags come from the registered level, so a pop cannot make room for a same-cycle push.
    assign full_o       = (count_q == FULL_LVL);
    assign empty_o      = (count_q == '0);
    assign do_push      = push_i && !full_o;
    assign do_pop       = pop_i && !empty_o;
    assign data_o       = mem_q[rd_ptr_q];
    assign empty_next_o = (count_d == '0);

    // Next fill level, also used by the parent to register its busy flag.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointers and level; pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/core_mem_port.sv
// rtl/core_mem_port.sv - per-core initiator issuing queued byte requests to the banked memory arbiters
module core_mem_port
    import core_mem_port_pkg::*;
#(
    parameter int CORE_ID    = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_wdata,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [DATA_W-1:0]         resp_rdata,
    output logic                      resp_write,
    output logic                      resp_err,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [N_BANKS-1:0]        bank_finish,
    input  logic [N_BANKS*DATA_W-1:0] bank_data,
    output logic                      busy
);

    if (CORE_ID < 0 || CORE_ID >= N_BANKS || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
        $error("core_mem_port: illegal parameter value");
    end

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]        tmo_q, tmo_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_write_q, resp_write_d;
    logic              resp_err_q, resp_err_d;
    logic              busy_q, busy_d;

    logic              fifo_full, fifo_empty, fifo_empty_next, fifo_pop;
    logic [REQ_W-1:0]  fifo_head_raw;
    req_t              head;
    req_t              push_req;
    logic [BANK_W-1:0] bank;
    logic              hit;
    logic [DATA_W-1:0] hit_data;

    assign push_req = '{write: req_write, addr: req_addr, wdata: req_wdata};
    assign head     = req_t'(fifo_head_raw);

    core_mem_port_req_fifo #(.DEPTH(FIFO_DEPTH)) u_req_fifo (
        .clk_i        (clock),
        .reset_i      (reset),
        .push_i       (req_valid),
        .data_i       (push_req),
        .pop_i        (fifo_pop),
        .data_o       (fifo_head_raw),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .empty_next_o (fifo_empty_next)
    );

    // Only the addressed bank's finish/data slice matters; the others belong to other traffic.
    assign bank     = mem_addr_q[ADDR_W-1:OFFS_W];
    assign hit      = bank_finish[bank];
    assign hit_data = bank_data[{bank, 3'b000} +: DATA_W];

    // Next-state and output logic for the IDLE -> ISSUE -> RESP request cycle.
    always_comb begin
        state_d      = state_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        tmo_d        = tmo_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_write_d = resp_write_q;
        resp_err_d   = resp_err_q;
        fifo_pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    mem_read_d  = !head.write;
                    mem_write_d = head.write;
                    mem_addr_d  = head.addr;
                    mem_wdata_d = head.wdata;
                    tmo_d       = '0;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (hit || tmo_q == TMO_LAST) begin
                    // A finish in the timeout cycle still completes the request cleanly.
                    resp_valid_d = 1'b1;
                    resp_write_d = mem_write_q;
                    resp_err_d   = !hit;
                    resp_rdata_d = (hit && mem_read_q) ? hit_data : '0;
                    mem_read_d   = 1'b0;
                    mem_write_d  = 1'b0;
                    mem_addr_d   = '0;
                    mem_wdata_d  = '0;
                    state_d      = ST_RESP;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE) || !fifo_empty_next;
    end

    // State and output registers; reset drops any in-flight request without a response.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            tmo_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_write_q <= 1'b0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            tmo_q        <= tmo_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_write_q <= resp_write_d;
            resp_err_q   <= resp_err_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready  = !fifo_full;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_write = resp_write_q;
    assign resp_err   = resp_err_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_core_mem_port.sv
// tb/tb_core_mem_port.sv - scoreboard bench for core_mem_port with a bank arbiter model
module tb_core_mem_port;

    logic         clock = 1'b0;
    logic         reset;
    logic         req_valid, req_ready, req_write;
    logic [11:0]  req_addr;
    logic [7:0]   req_wdata;
    logic         resp_valid, resp_ready, resp_write, resp_err;
    logic [7:0]   resp_rdata;
    logic         mem_read, mem_write;
    logic [11:0]  mem_addr;
    logic [7:0]   mem_wdata;
    logic [15:0]  bank_finish;
    logic [127:0] bank_data;
    logic         busy;

    logic [15:0]  arb_finish = '0;
    logic [127:0] arb_data   = '0;
    logic [15:0]  man_finish = '0;
    logic [127:0] man_data   = '0;
    bit           arb_auto   = 1'b1;
    int           arb_delay  = 3;
    int           arb_cnt    = 0;
    logic [7:0]   mem_model [4096];

    int n_checks = 0;
    int n_fail   = 0;
    logic [9:0] exp_q [$];

    assign bank_finish = arb_finish | man_finish;
    assign bank_data   = arb_auto ? arb_data : man_data;

    always #5 clock = ~clock;

    core_mem_port #(.CORE_ID(3), .FIFO_DEPTH(4), .TIMEOUT(10)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_write  (resp_write),
        .resp_err    (resp_err),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .bank_finish (bank_finish),
        .bank_data   (bank_data),
        .busy        (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Arbiter model: finish pulse arb_delay cycles after read/write rises.
    always @(negedge clock) begin
        logic [3:0] b;
        arb_finish = '0;
        if (reset || !arb_auto || !(mem_read || mem_write)) begin
            arb_cnt = 0;
        end else begin
            arb_cnt++;
            if (arb_cnt == arb_delay) begin
                b = mem_addr[11:8];
                if (mem_write) mem_model[mem_addr] = mem_wdata;
                arb_data = '0;
                arb_data[8*b +: 8] = mem_write ? 8'h00 : mem_model[mem_addr];
                arb_finish[b] = 1'b1;
            end
        end
    end

    // Monitor: every accepted response is compared against the oldest expectation.
    always @(negedge clock) begin
        logic [9:0] e;
        if (!reset && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("resp_fields", {22'd0, resp_write, resp_err, resp_rdata}, {22'd0, e});
            end
        end
    end

    task automatic push(input logic w, input logic [11:0] a, input logic [7:0] d,
                        input logic [7:0] er, input logic ee, input bit track);
        bit ok = 1'b0;
        req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (req_ready) ok = 1'b1;
            @(posedge clock);
            if (ok && track) exp_q.push_back({w, ee, er});
            @(negedge clock);
        end
        req_valid = 1'b0;
        if (!ok) chk("push_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_mem();
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (mem_read || mem_write) seen = 1'b1;
            else @(negedge clock);
        end
        if (!seen) chk("issue_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 300 && !idle; i++) begin
            @(negedge clock);
            if (!busy && !resp_valid && exp_q.size() == 0) idle = 1'b1;
        end
        if (!idle) chk("idle_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem_model[i] = 8'h00;
        mem_model[12'h3A5] = 8'h5C;
        reset = 1'b1; resp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h3A5; req_wdata = 8'h00;
        repeat (3) @(negedge clock);
        chk("rst_req_ready", 32'(req_ready), 32'(1));
        chk("rst_outputs", {resp_valid, resp_write, resp_err, mem_read, mem_write, busy},
            6'b0);
        chk("rst_data", {resp_rdata, mem_addr, mem_wdata}, 28'h0);

        // Release reset: push lands on the very next edge, mem_read one edge later.
        reset = 1'b0;
        @(posedge clock);
        exp_q.push_back({1'b0, 1'b0, 8'h5C});
        @(negedge clock);
        req_valid = 1'b0;
        chk("first_push_busy", 32'(busy), 32'(1));
        chk("mem_read_not_yet", 32'(mem_read), 32'(0));
        @(negedge clock);
        chk("mem_read_rise", {mem_read, mem_write, mem_addr}, {2'b10, 12'h3A5});
        repeat (2) @(negedge clock);
        chk("mem_read_held", 32'(mem_read), 32'(1));
        @(negedge clock);
        chk("mem_read_drop", {mem_read, resp_valid}, 2'b01);
        wait_idle();

        // Write then read the same byte: responses come back in order.
        push(1'b1, 12'hF00, 8'h7F, 8'h00, 1'b0, 1'b1);
        push(1'b0, 12'hF00, 8'h00, 8'h7F, 1'b0, 1'b1);
        wait_idle();

        // A finish from another bank is ignored; bank 2's finish completes the read.
        arb_auto = 1'b0;
        push(1'b0, 12'h2AB, 8'h00, 8'h91, 1'b0, 1'b1);
        wait_mem();
        man_finish = 16'h0020; man_data = 128'hEE << 40;
        @(negedge clock);
        man_finish = '0;
        chk("other_bank_ignored", {mem_read, resp_valid}, 2'b10);
        @(negedge clock);
        chk("still_issue", 32'(mem_read), 32'(1));
        man_finish = 16'h0004; man_data = 128'h91 << 16;
        @(negedge clock);
        man_finish = '0;
        chk("bank2_done", {mem_read, resp_valid}, 2'b01);
        wait_idle();

        // Timeout on ISSUE cycle 10, then the queued write runs normally.
        push(1'b0, 12'h444, 8'h00, 8'h00, 1'b1, 1'b1);
        push(1'b1, 12'h1AA, 8'h33, 8'h00, 1'b0, 1'b1);
        wait_mem();
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("tmo_wait_%0d", k), {mem_read, resp_valid}, 2'b10);
            @(negedge clock);
        end
        chk("tmo_resp", {mem_read, resp_valid, resp_err}, 3'b011);
        arb_auto = 1'b1;
        wait_idle();
        chk("write_stored", 32'(mem_model[12'h1AA]), 32'h33);

        // Fill the queue behind a stalled request, then reset mid-ISSUE.
        arb_auto = 1'b0; resp_ready = 1'b0;
        push(1'b0, 12'h100, 8'h00, 8'h00, 1'b0, 1'b0);
        wait_mem();
        for (int k = 1; k <= 4; k++) push(1'b0, 12'h100 + 12'(k), 8'h00, 8'h00, 1'b0, 1'b0);
        chk("full_ready_low", 32'(req_ready), 32'(0));
        req_valid = 1'b1; req_addr = 12'h105;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        chk("fifth_refused", {req_ready, mem_read}, 2'b01);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_issue", {mem_read, mem_write, resp_valid, busy, req_ready}, 5'b00001);
        reset = 1'b0; resp_ready = 1'b1;
        begin
            bit quiet = 1'b1;
            for (int k = 0; k < 16; k++) begin
                @(negedge clock);
                if (resp_valid || mem_read || mem_write || busy) quiet = 1'b0;
            end
            chk("dropped_after_reset", 32'(quiet), 32'(1));
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
